// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : map_pkg
// Description : Shared map geometry, video timing limits, tile codes and the
//               arbiter state type for the map tile arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package map_pkg;

    // Map geometry in tiles (8x8-pixel tiles over a 1280x720 frame)
    localparam int MAP_W    = 160;
    localparam int MAP_H    = 90;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;

    typedef enum logic [3:0] {
        TILE_VOID     = 4'd0,
        TILE_WALL     = 4'd1,
        TILE_GRASS    = 4'd2,
        TILE_SAND     = 4'd3,
        TILE_DIAG_NE  = 4'd4,
        TILE_DIAG_NW  = 4'd5,
        TILE_DIAG_SE  = 4'd6,
        TILE_DIAG_SW  = 4'd7,
        TILE_DIAG_NE2 = 4'd8,
        TILE_DIAG_NW2 = 4'd9,
        TILE_DIAG_SE2 = 4'd10,
        TILE_DIAG_SW2 = 4'd11
    } tile_code_t;

    typedef enum logic [1:0] {
        ARB_VIDEO = 2'd0,
        ARB_BLANK = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_t;

    // Row-major map RAM address of a tile
    function automatic logic [13:0] tile_addr(input logic [6:0] row,
                                              input logic [7:0] col);
        return 14'(row) * 14'(MAP_W) + 14'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/map_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : map_req_fifo
// Description : Synchronous first-word-fall-through request FIFO. The head
//               entry is visible on o_data whenever o_empty is low; i_pop
//               retires it. Push and pop in the same cycle are allowed,
//               including when full (the head is read before being replaced).
// Ports       : clk, rst_n (async, active-low)
//               i_push/i_data  - write side
//               i_pop/o_data   - read side (FWFT)
//               o_empty/o_full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module map_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/map_tile_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : map_tile_arbiter
// Description : Shares one map tile RAM between the video pipeline and a
//               physics lookup queue. Video owns the RAM during the active
//               region; queued physics requests are served one per cycle in
//               blanking, limited to FRAME_BUDGET grants per frame.
// Ports       : pixel_clk_in, rst_in (async, active-low)
//               hcount_in/vcount_in            - video raster position
//               phys_req_*                     - physics request (valid/ready)
//               phys_rsp_*                     - physics response strobe/tile
//               ram_addr_out/ram_dout_in       - map RAM (2-cycle read latency)
//               pix_tile_out/pix_valid_out     - video tile stream
//               stat_grants_out/stat_stall_out - last-frame statistics
// Options     : MAP_ARB_STATS_EN - build the per-frame statistic counters;
//               when undefined the stat outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module map_tile_arbiter
    import map_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_BUDGET = 256
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        phys_req_valid_in,
    output logic        phys_req_ready_out,
    input  logic [7:0]  phys_tile_x_in,
    input  logic [6:0]  phys_tile_y_in,
    output logic        phys_rsp_valid_out,
    output logic [3:0]  phys_rsp_tile_out,
    output logic [13:0] ram_addr_out,
    input  logic [3:0]  ram_dout_in,
    output logic [3:0]  pix_tile_out,
    output logic        pix_valid_out,
    output logic [15:0] stat_grants_out,
    output logic [15:0] stat_stall_out
);

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic [14:0] w_head;
    logic [7:0]  w_head_x;
    logic [6:0]  w_head_y;
    logic        w_head_oor;

    assign phys_req_ready_out = rst_in && (!w_full || w_pop);
    assign w_push             = phys_req_valid_in && phys_req_ready_out;

    map_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (15)
    ) u_fifo (
        .clk     (pixel_clk_in),
        .rst_n   (rst_in),
        .i_push  (w_push),
        .i_data  ({phys_tile_y_in, phys_tile_x_in}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_head_x   = w_head[7:0];
    assign w_head_y   = w_head[14:8];
    assign w_head_oor = (int'(w_head_x) >= MAP_W) || (int'(w_head_y) >= MAP_H);

    // ------------------------------------------------------------------
    // Arbitration state. Derived from the raster position every cycle so
    // video is never delayed by even one cycle of state latency; the
    // budget register is what carries HOLD across the blanking interval.
    // ------------------------------------------------------------------
    logic [15:0] r_budget;
    arb_state_t  w_state;
    logic        w_active;
    logic        w_budget_left;
    logic        w_frame_start;

    assign w_active      = (int'(vcount_in) < V_ACTIVE) && (int'(hcount_in) < H_ACTIVE);
    assign w_budget_left = ({16'd0, r_budget} < 32'(FRAME_BUDGET));
    assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    always_comb begin
        w_state = ARB_HOLD;
        if (w_active) begin
            w_state = ARB_VIDEO;
        end else if (w_budget_left) begin
            w_state = ARB_BLANK;
        end
    end

    assign w_pop = (w_state == ARB_BLANK) && !w_empty;

    // ------------------------------------------------------------------
    // RAM address mux
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr_out = 14'd0;
        if (w_state == ARB_VIDEO) begin
            ram_addr_out = tile_addr(vcount_in[9:3], hcount_in[10:3]);
        end else if (w_pop && !w_head_oor) begin
            ram_addr_out = tile_addr(w_head_y, w_head_x);
        end
    end

    // ------------------------------------------------------------------
    // Budget counter: cleared at frame start, but a grant in that same
    // cycle already belongs to the new frame.
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_budget <= 16'd0;
        end else if (w_frame_start) begin
            r_budget <= w_pop ? 16'd1 : 16'd0;
        end else if (w_pop && (r_budget != 16'hFFFF)) begin
            r_budget <= r_budget + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read tags: index 0 is one cycle after the address, index 1 lines up
    // with ram_dout_in for that address.
    // ------------------------------------------------------------------
    logic [1:0] r_tag_vld;
    logic [1:0] r_tag_phys;
    logic [1:0] r_tag_oor;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tag_vld  <= 2'b00;
            r_tag_phys <= 2'b00;
            r_tag_oor  <= 2'b00;
        end else begin
            r_tag_vld  <= {r_tag_vld[0],  (w_state == ARB_VIDEO) || w_pop};
            r_tag_phys <= {r_tag_phys[0], w_pop};
            r_tag_oor  <= {r_tag_oor[0],  w_pop && w_head_oor};
        end
    end

    assign phys_rsp_valid_out = r_tag_vld[1] && r_tag_phys[1];
    assign phys_rsp_tile_out  = (phys_rsp_valid_out && !r_tag_oor[1]) ? ram_dout_in
                                                                      : 4'(TILE_VOID);
    assign pix_valid_out      = r_tag_vld[1] && !r_tag_phys[1];
    assign pix_tile_out       = pix_valid_out ? ram_dout_in : 4'(TILE_VOID);

    // ------------------------------------------------------------------
    // Per-frame statistics
    // ------------------------------------------------------------------
`ifdef MAP_ARB_STATS_EN
    logic        w_stall;
    logic [15:0] r_cnt_grants;
    logic [15:0] r_cnt_stall;
    logic [15:0] r_stat_grants;
    logic [15:0] r_stat_stall;

    assign w_stall = !w_empty && !w_pop;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt_grants  <= 16'd0;
            r_cnt_stall   <= 16'd0;
            r_stat_grants <= 16'd0;
            r_stat_stall  <= 16'd0;
        end else if (w_frame_start) begin
            // Publish the finished frame; this cycle opens the new one.
            r_stat_grants <= r_cnt_grants;
            r_stat_stall  <= r_cnt_stall;
            r_cnt_grants  <= w_pop   ? 16'd1 : 16'd0;
            r_cnt_stall   <= w_stall ? 16'd1 : 16'd0;
        end else begin
            if (w_pop && (r_cnt_grants != 16'hFFFF)) begin
                r_cnt_grants <= r_cnt_grants + 16'd1;
            end
            if (w_stall && (r_cnt_stall != 16'hFFFF)) begin
                r_cnt_stall <= r_cnt_stall + 16'd1;
            end
        end
    end

    assign stat_grants_out = r_stat_grants;
    assign stat_stall_out  = r_stat_stall;
`else
    assign stat_grants_out = 16'd0;
    assign stat_stall_out  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_map_tile_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_tile_arbiter
// Description : Directed self-checking bench for map_tile_arbiter
//               (FIFO_DEPTH=4, FRAME_BUDGET=8). The map RAM is modelled with
//               a 2-cycle read pipeline returning a[3:0]^a[7:4]^4'h5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_tile_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  tx;
    logic [6:0]  ty;
    logic        rsp_valid;
    logic [3:0]  rsp_tile;
    logic [13:0] ram_addr;
    logic [3:0]  ram_dout;
    logic [3:0]  pix_tile;
    logic        pix_valid;
    logic [15:0] stat_grants;
    logic [15:0] stat_stall;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    map_tile_arbiter #(
        .FIFO_DEPTH   (4),
        .FRAME_BUDGET (8)
    ) dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst_n),
        .hcount_in          (hc),
        .vcount_in          (vc),
        .phys_req_valid_in  (req_valid),
        .phys_req_ready_out (req_ready),
        .phys_tile_x_in     (tx),
        .phys_tile_y_in     (ty),
        .phys_rsp_valid_out (rsp_valid),
        .phys_rsp_tile_out  (rsp_tile),
        .ram_addr_out       (ram_addr),
        .ram_dout_in        (ram_dout),
        .pix_tile_out       (pix_tile),
        .pix_valid_out      (pix_valid),
        .stat_grants_out    (stat_grants),
        .stat_stall_out     (stat_stall)
    );

    // Map RAM: data for an address appears two cycles later
    logic [13:0] r_a1 = '0;
    logic [13:0] r_a2 = '0;
    always @(posedge clk) begin
        r_a1 <= ram_addr;
        r_a2 <= r_a1;
    end
    assign ram_dout = r_a2[3:0] ^ r_a2[7:4] ^ 4'h5;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, apply inputs, let them settle
    task automatic cyc(input int h, input int v, input logic val,
                       input int x, input int y);
        @(posedge clk);
        #1;
        hc        = 11'(h);
        vc        = 10'(v);
        req_valid = val;
        tx        = 8'(x);
        ty        = 7'(y);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hc = '0; vc = '0; req_valid = 1'b0; tx = '0; ty = '0;

        // ---------------- reset state ----------------
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_ready",     16'(req_ready),   16'd0);
        chk("rst_rsp_valid", 16'(rsp_valid),   16'd0);
        chk("rst_pix_valid", 16'(pix_valid),   16'd0);
        chk("rst_stat_g",    stat_grants,      16'd0);
        chk("rst_addr",      16'(ram_addr),    16'd0);

        rst_n = 1'b1;
        cyc(1300, 0, 0, 0, 0);
        cyc(1300, 0, 0, 0, 0);
        cyc(1300, 0, 0, 0, 0);

        // ---------------- video address (1000,16) -> 445 ----------------
        cyc(1000, 16, 0, 0, 0);
        chk("vid_addr",      16'(ram_addr),    16'd445);
        chk("vid_pix_v0",    16'(pix_valid),   16'd0);
        cyc(1300, 16, 0, 0, 0);
        chk("vid_blank_addr",16'(ram_addr),    16'd0);
        chk("vid_pix_v1",    16'(pix_valid),   16'd0);
        cyc(1300, 16, 0, 0, 0);
        chk("vid_pix_v2",    16'(pix_valid),   16'd1);
        chk("vid_pix_tile",  16'(pix_tile),    16'h3);
        cyc(1300, 16, 0, 0, 0);
        chk("vid_pix_v3",    16'(pix_valid),   16'd0);

        // ---------------- single request (5,3) -> RAM[485] ----------------
        cyc(100, 100, 1, 5, 3);
        chk("one_ready",     16'(req_ready),   16'd1);
        cyc(1300, 100, 0, 0, 0);
        chk("one_addr",      16'(ram_addr),    16'd485);
        chk("one_rsp_v1",    16'(rsp_valid),   16'd0);
        cyc(1300, 100, 0, 0, 0);
        chk("one_rsp_v2",    16'(rsp_valid),   16'd0);
        cyc(1300, 100, 0, 0, 0);
        chk("one_rsp_v3",    16'(rsp_valid),   16'd1);
        chk("one_rsp_tile",  16'(rsp_tile),    16'hE);
        cyc(1300, 100, 0, 0, 0);
        chk("one_rsp_v4",    16'(rsp_valid),   16'd0);

        cyc(0, 0, 0, 0, 0);

        // ---------------- 5 back-to-back pushes, depth 4 ----------------
        cyc(200, 200, 1, 1, 1);  chk("b2b_ready0", 16'(req_ready), 16'd1);
        cyc(200, 200, 1, 2, 2);  chk("b2b_ready1", 16'(req_ready), 16'd1);
        cyc(200, 200, 1, 3, 3);  chk("b2b_ready2", 16'(req_ready), 16'd1);
        cyc(200, 200, 1, 4, 4);  chk("b2b_ready3", 16'(req_ready), 16'd1);
        cyc(200, 200, 1, 6, 7);  chk("b2b_ready4", 16'(req_ready), 16'd0);
        cyc(1300, 200, 1, 6, 7);
        chk("b2b_ready_pp",  16'(req_ready),   16'd1);
        chk("b2b_addr0",     16'(ram_addr),    16'd161);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_addr1",     16'(ram_addr),    16'd322);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_addr2",     16'(ram_addr),    16'd483);
        chk("b2b_rsp_v0",    16'(rsp_valid),   16'd1);
        chk("b2b_rsp_t0",    16'(rsp_tile),    16'hE);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_addr3",     16'(ram_addr),    16'd644);
        chk("b2b_rsp_t1",    16'(rsp_tile),    16'h3);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_addr4",     16'(ram_addr),    16'd1126);
        chk("b2b_rsp_t2",    16'(rsp_tile),    16'h8);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_addr_idle", 16'(ram_addr),    16'd0);
        chk("b2b_rsp_t3",    16'(rsp_tile),    16'h9);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_rsp_v4",    16'(rsp_valid),   16'd1);
        chk("b2b_rsp_t4",    16'(rsp_tile),    16'h5);
        cyc(1300, 200, 0, 0, 0);
        chk("b2b_rsp_end",   16'(rsp_valid),   16'd0);

        cyc(0, 0, 0, 0, 0);

        // ---------------- out-of-range request (200,10) ----------------
        cyc(100, 100, 1, 200, 10);
        chk("oor_ready",     16'(req_ready),   16'd1);
        cyc(1300, 100, 0, 0, 0);
        chk("oor_addr",      16'(ram_addr),    16'd0);
        cyc(1300, 100, 0, 0, 0);
        chk("oor_rsp_v2",    16'(rsp_valid),   16'd0);
        cyc(1300, 100, 0, 0, 0);
        chk("oor_rsp_v3",    16'(rsp_valid),   16'd1);
        chk("oor_rsp_tile",  16'(rsp_tile),    16'h0);

        cyc(0, 0, 0, 0, 0);

        // ---------------- budget of 8 with 12 requests ----------------
        for (int i = 0; i < 12; i++) begin
            cyc(1300, 100, 1, 10 + i, 1);
            chk("bud_ready", 16'(req_ready), 16'd1);
            if (i == 1)  chk("bud_addr_first", 16'(ram_addr), 16'd170);
            if (i == 3)  chk("bud_rsp_tile0",  16'(rsp_tile), 16'h5);
            if (i == 8)  chk("bud_addr_last",  16'(ram_addr), 16'd177);
            if (i == 9)  chk("bud_hold_addr",  16'(ram_addr), 16'd0);
            if (i == 10) chk("bud_rsp_last",   16'(rsp_valid), 16'd1);
            if (i == 11) chk("bud_hold_rsp",   16'(rsp_valid), 16'd0);
        end
        cyc(1300, 100, 0, 0, 0);
        chk("bud_full_ready", 16'(req_ready),  16'd0);
        chk("bud_hold_addr2", 16'(ram_addr),   16'd0);
        cyc(1300, 100, 0, 0, 0);
        chk("bud_hold_addr3", 16'(ram_addr),   16'd0);
        chk("bud_hold_rsp2",  16'(rsp_valid),  16'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(1300, 100, 0, 0, 0);
        chk("bud_new_addr0",  16'(ram_addr),   16'd178);
`ifdef MAP_ARB_STATS_EN
        chk("stat_grants",    stat_grants,     16'd8);
        chk("stat_stall",     stat_stall,      16'd5);
`else
        chk("stat_grants",    stat_grants,     16'd0);
        chk("stat_stall",     stat_stall,      16'd0);
`endif
        cyc(1300, 100, 0, 0, 0);
        chk("bud_new_addr1",  16'(ram_addr),   16'd179);
        cyc(1300, 100, 0, 0, 0);
        chk("bud_new_addr2",  16'(ram_addr),   16'd180);
        cyc(1300, 100, 0, 0, 0);
        chk("bud_new_addr3",  16'(ram_addr),   16'd181);
        cyc(1300, 100, 0, 0, 0);
        chk("bud_new_idle",   16'(ram_addr),   16'd0);

        cyc(0, 0, 0, 0, 0);

        // ---------------- reset one cycle after a grant ----------------
        cyc(100, 100, 1, 20, 2);
        chk("rr_ready0",     16'(req_ready),   16'd1);
        cyc(101, 100, 1, 21, 2);
        cyc(1300, 100, 0, 0, 0);
        chk("rr_grant_addr", 16'(ram_addr),    16'd340);
        cyc(1300, 100, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rr_in_ready",   16'(req_ready),   16'd0);
        chk("rr_in_rsp",     16'(rsp_valid),   16'd0);
        cyc(1300, 100, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("rr_rel_rsp",    16'(rsp_valid),   16'd0);
        chk("rr_rel_ready",  16'(req_ready),   16'd1);
        chk("rr_rel_addr",   16'(ram_addr),    16'd0);
        cyc(1300, 100, 0, 0, 0);
        chk("rr_post_rsp",   16'(rsp_valid),   16'd0);
        chk("rr_post_addr",  16'(ram_addr),    16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/map_tile_arbiter.md
MAP_TILE_ARBITER -- requirements
Module: map_tile_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning physics request queue depth (power of 2, at least 2).
REQ-002 SHALL have parameter FRAME_BUDGET, default 256, meaning the maximum physics RAM grants per frame.
REQ-003 SHALL have port pixel_clk_in, input, 1, the single clock.
REQ-004 SHALL have port rst_in, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port hcount_in, input, 11, video horizontal count.
REQ-006 SHALL have port vcount_in, input, 10, video vertical count.
REQ-007 SHALL have port phys_req_valid_in, input, 1, physics tile lookup request.
REQ-008 SHALL have port phys_req_ready_out, output, 1, request accepted when high together with valid.
REQ-009 SHALL have port phys_tile_x_in, input, 8, tile column.
REQ-010 SHALL have port phys_tile_y_in, input, 7, tile row.
REQ-011 SHALL have port phys_rsp_valid_out, output, 1, one-cycle response strobe.
REQ-012 SHALL have port phys_rsp_tile_out, output, 4, tile code.
REQ-013 SHALL have port ram_addr_out, output, 14, map RAM address.
REQ-014 SHALL have port ram_dout_in, input, 4, map RAM data, which arrives 2 cycles after the address.
REQ-015 SHALL have port pix_tile_out, output, 4, tile code for the video pipeline.
REQ-016 SHALL have port pix_valid_out, output, 1, marks pix_tile_out as a video read.
REQ-017 SHALL have port stat_grants_out, output, 16, physics grants in the last completed frame.
REQ-018 SHALL have port stat_stall_out, output, 16, cycles in the last completed frame with the FIFO non-empty and no grant issued.

Function
REQ-019 SHALL run a state machine with states VIDEO, BLANK and HOLD.
REQ-020 SHALL be in VIDEO when vcount_in<720 and hcount_in<1280, else in BLANK when the budget remains, else in HOLD.
REQ-021 SHALL drive ram_addr_out=(vcount_in>>3)*160+(hcount_in>>3) combinationally in VIDEO; video always wins and is never delayed.
REQ-022 SHALL pop one FIFO entry per cycle in BLANK when the FIFO is non-empty, drive ram_addr_out=y*160+x, and increment the budget counter.
REQ-023 SHALL accept a request as pushed when phys_req_valid_in and phys_req_ready_out are both high; phys_req_ready_out SHALL be high iff the FIFO is not full, or a pop occurs in the same cycle.
REQ-024 SHALL allow a simultaneous push and pop with the count unchanged; a push to a full FIFO with no pop SHALL never occur because ready is low.
REQ-025 SHALL treat a request with x>=160 or y>=90 as out of range: it consumes a grant, drives address 0, and responds with tile 4'h0.
REQ-026 SHALL tag each issued read in a 2-stage owner/valid/out-of-range shift register, so that phys_rsp_valid_out pulses exactly 2 cycles after the pop and responses are returned in request order.
REQ-027 SHALL drive pix_valid_out high 2 cycles after each VIDEO-state address, with pix_tile_out=ram_dout_in on that cycle.
REQ-028 SHALL drive ram_addr_out=0 and issue no tag when in BLANK with an empty FIFO, or in HOLD.
REQ-029 SHALL, on reaching FRAME_BUDGET grants, enter HOLD until frame start (hcount_in==0 and vcount_in==0), where the budget counter clears; a grant issued in the frame-start cycle SHALL count toward the new frame.
REQ-030 SHALL saturate budget and stat counters at their maximum and never wrap.

Reset
REQ-031 SHALL, on rst_in low, asynchronously clear the FIFO, tags, budget counter and stat registers, set the state to BLANK, and drive all outputs 0 except ram_addr_out, which follows REQ-021/REQ-028.
REQ-032 SHALL discard reads in flight at reset; no response SHALL be emitted for them after reset is released.

Configuration
REQ-033 SHALL compile stat counters in when MAP_ARB_STATS_EN is defined, latching them into stat_* at frame start.
REQ-034 SHALL, when MAP_ARB_STATS_EN is undefined, tie stat_grants_out and stat_stall_out to 0 and infer no counter logic.

Structure
REQ-035 SHALL place MAP_W=160, MAP_H=90, H_ACTIVE=1280, V_ACTIVE=720, the tile code enum (0 void, 1 wall, 2 grass, 3 sand, 4-11 diagonal walls) and the arb_state_t typedef in package map_pkg.
REQ-036 SHALL instantiate the queue as sub-module map_req_fifo, a synchronous first-word-fall-through FIFO.

Verification
REQ-037 Bench SHALL cover: push (x=5,y=3) during active video -> ready high; response tile=RAM[485] 2 cycles after the first blanking cycle.
REQ-038 Bench SHALL cover: 5 back-to-back pushes with FIFO_DEPTH=4 during active video -> ready low on the 5th push; all 5 responses in order during blanking.
REQ-039 Bench SHALL cover: push (x=200,y=10) -> tile 0 response, with ram_addr_out=0 on the grant cycle.
REQ-040 Bench SHALL cover: FRAME_BUDGET=8 with 12 queued requests -> 8 grants, then HOLD; the remaining 4 are granted after frame start; with MAP_ARB_STATS_EN, stat_grants_out=8.
REQ-041 Bench SHALL cover: hcount_in=1000, vcount_in=16 -> ram_addr_out=445, and pix_valid_out high 2 cycles later.
REQ-042 Bench SHALL cover: rst_in asserted 1 cycle after a grant -> no phys_rsp_valid_out; FIFO empty and ready high after release.
